// File: rtl/fir_pkg.sv
// Shared types and arithmetic helpers for the FIR output stages.
package fir_pkg;

  // Coefficient symmetry of the FIR core feeding the output stage.
  typedef enum logic [1:0] {
    NONSYM,
    SYM,
    ANTISYM
  } sym_e;

  // Wide signed working type; any realistic filter result plus the rounding
  // constant fits without overflow once sign-extended into it.
  localparam int CALC_W = 64;
  typedef logic signed [CALC_W-1:0] calc_t;

  // Result of a clamp: the value plus whether a limit was applied.
  typedef struct packed {
    calc_t value;
    logic  clamped;
  } sat_t;

  // Bit width needed to index n items; never less than one bit.
  function automatic int width_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Round half up: add half an output LSB, then drop 'shift' LSBs arithmetically.
  function automatic calc_t round_half_up(input calc_t x, input int shift);
    calc_t half;
    half = calc_t'(1) <<< (shift - 1);
    return (x + half) >>> shift;
  endfunction

  // Clamp a signed value to the range of an out_w-bit two's-complement word.
  function automatic sat_t saturate(input calc_t r, input int out_w);
    calc_t hi;
    calc_t lo;
    sat_t  res;
    hi          = (calc_t'(1) <<< (out_w - 1)) - calc_t'(1);
    lo          = -(calc_t'(1) <<< (out_w - 1));
    res.clamped = 1'b1;
    if (r > hi) begin
      res.value = hi;
    end else if (r < lo) begin
      res.value = lo;
    end else begin
      res.value   = r;
      res.clamped = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// Synchronous FIFO with a registered first-word-fall-through output.
// An entry becomes visible on rd_valid one cycle after it is written; a push
// into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module fir_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_next;
  logic [LW-1:0]    count;
  logic [LW-1:0]    count_next;
  logic             pop;
  logic             full;
  logic             accept;
  logic             show;

  // Push/pop decisions and next occupancy from the current state.
  // NOTE: every signal assigned here gets a value on every path (defaults first), otherwise a latch is inferred.
  always_comb begin
    pop         = rd_valid && rd_ready;
    full        = (count == LW'(DEPTH));
    accept      = push && (!full || pop);
    drop        = push && full && !pop;
    rd_ptr_next = pop ? rd_ptr + AW'(1) : rd_ptr;
    count_next  = count;
    case ({accept, pop})
      2'b10:   count_next = count + LW'(1);
      2'b01:   count_next = count - LW'(1);
      default: count_next = count;
    endcase
    // Only entries written before this edge may be presented next cycle.
    show        = (count > LW'(pop));
  end

  // Storage write port.
  // NOTE: the storage array is deliberately not reset; pointers and count define which entries are meaningful, and an unreset array maps onto RAM.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers, occupancy and the registered output word.
  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values, whatever the statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr   <= rd_ptr_next;
      count    <= count_next;
      rd_valid <= show;
      if (show) begin
        rd_data <= mem[rd_ptr_next];
      end
    end
  end

  assign level = count;

endmodule

// File: rtl/fir_decim_out.sv
// FIR output stage: decimate, round half up, saturate, register once, then
// buffer in a FWFT FIFO toward a ready/valid consumer. Sticky flags report
// saturation and samples lost to a full FIFO.
module fir_decim_out
  import fir_pkg::*;
#(
  parameter int INPUT_WIDTH  = 26,
  parameter int OUTPUT_WIDTH = 16,
  parameter int SHIFT        = 10,
  parameter int DECIM        = 4,
  parameter int DECIM_PHASE  = 0,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          valid_in,
  input  logic [INPUT_WIDTH-1:0]        din,
  input  logic                          sync,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [OUTPUT_WIDTH-1:0]       m_data,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          ovf,
  output logic                          sat,
  input  logic                          flag_clr
);

  localparam int PHASE_W = width_of(DECIM);
  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(DECIM - 1);
  localparam logic [PHASE_W-1:0] KEEP_PHASE = PHASE_W'(DECIM_PHASE);
  // After a sync the realigned sample was phase 0, so the next one is phase 1.
  localparam logic [PHASE_W-1:0] SYNC_LOAD  = (DECIM == 1) ? '0 : PHASE_W'(1);

  logic [PHASE_W-1:0]      phase;
  logic [PHASE_W-1:0]      eff_phase;
  logic [PHASE_W-1:0]      phase_next;
  logic                    keep;
  calc_t                   din_ext;
  sat_t                    sat_res;
  logic                    pipe_valid;
  logic [OUTPUT_WIDTH-1:0] pipe_data;
  logic                    fifo_drop;

  assign din_ext = calc_t'($signed(din));
  assign sat_res = saturate(round_half_up(din_ext, SHIFT), OUTPUT_WIDTH);

  // Phase selection: sync forces the current sample to phase 0.
  always_comb begin
    eff_phase  = sync ? '0 : phase;
    keep       = valid_in && (eff_phase == KEEP_PHASE);
    phase_next = phase;
    if (sync) begin
      phase_next = valid_in ? SYNC_LOAD : '0;
    end else if (valid_in) begin
      phase_next = (phase == LAST_PHASE) ? '0 : phase + PHASE_W'(1);
    end
  end

  // Phase counter and the single round/saturate pipeline register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      phase      <= '0;
      pipe_valid <= 1'b0;
      pipe_data  <= '0;
    end else begin
      phase      <= phase_next;
      pipe_valid <= keep;
      if (keep) begin
        pipe_data <= OUTPUT_WIDTH'(sat_res.value);
      end
    end
  end

  // Sticky status flags; a new event in the clear cycle keeps the flag set.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf <= 1'b0;
      sat <= 1'b0;
    end else begin
      ovf <= fifo_drop | (ovf & ~flag_clr);
      sat <= (keep & sat_res.clamped) | (sat & ~flag_clr);
    end
  end

  fir_sync_fifo #(
    .WIDTH (OUTPUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (pipe_valid),
    .wdata    (pipe_data),
    .rd_ready (m_ready),
    .rd_valid (m_valid),
    .rd_data  (m_data),
    .level    (level),
    .drop     (fifo_drop)
  );

endmodule

// File: tb/tb_fir_decim_out.sv
// Bench for fir_decim_out: two instances (DECIM=1 and DECIM=4) share the
// input stream; a queue-based reference model predicts every output.
module tb_fir_decim_out;

  localparam int IW    = 26;
  localparam int OW    = 16;
  localparam int SH    = 10;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_in;
  logic [IW-1:0] din;
  logic          sync;
  logic          flag_clr;
  logic          rdy   [2];
  logic          mv    [2];
  logic [OW-1:0] md    [2];
  logic [3:0]    lvl   [2];
  logic          ovf_o [2];
  logic          sat_o [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fir_decim_out #(
    .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .SHIFT(SH),
    .DECIM(1), .DECIM_PHASE(0), .FIFO_DEPTH(DEPTH)
  ) u_d1 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .din(din), .sync(sync),
    .m_valid(mv[0]), .m_ready(rdy[0]), .m_data(md[0]), .level(lvl[0]),
    .ovf(ovf_o[0]), .sat(sat_o[0]), .flag_clr(flag_clr)
  );

  fir_decim_out #(
    .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .SHIFT(SH),
    .DECIM(4), .DECIM_PHASE(0), .FIFO_DEPTH(DEPTH)
  ) u_d4 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .din(din), .sync(sync),
    .m_valid(mv[1]), .m_ready(rdy[1]), .m_data(md[1]), .level(lvl[1]),
    .ovf(ovf_o[1]), .sat(sat_o[1]), .flag_clr(flag_clr)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int  mq      [2][$];
  int  m_phase [2];
  bit  m_pend_v[2];
  int  m_pend_d[2];
  bit  m_valid [2];
  int  m_data  [2];
  bit  m_ovf   [2];
  bit  m_sat   [2];
  int  out_log [2][$];

  task automatic model_step(input int i);
    int     dec, eff, old_size;
    bit     pop, keep, clamp, ovf_set;
    longint r;
    dec = (i == 0) ? 1 : 4;
    if (!rst) begin
      mq[i].delete();
      m_phase[i] = 0; m_pend_v[i] = 0; m_pend_d[i] = 0;
      m_valid[i] = 0; m_data[i]   = 0; m_ovf[i]    = 0; m_sat[i] = 0;
      return;
    end
    // FIFO side: pop, then the sample kept last cycle arrives.
    old_size = mq[i].size();
    pop      = m_valid[i] && rdy[i];
    if (pop) void'(mq[i].pop_front());
    ovf_set = 0;
    if (m_pend_v[i]) begin
      if (old_size < DEPTH || pop) mq[i].push_back(m_pend_d[i]);
      else ovf_set = 1;
    end
    // Only samples already stored before this edge are presented.
    m_valid[i] = (old_size - int'(pop)) > 0;
    if (m_valid[i]) m_data[i] = mq[i][0];
    // Decimation and arithmetic on the current input.
    eff  = sync ? 0 : m_phase[i];
    keep = valid_in && (eff == 0);
    if (valid_in)  m_phase[i] = (eff + 1) % dec;
    else if (sync) m_phase[i] = 0;
    r     = (longint'($signed(din)) + (longint'(1) << (SH - 1))) >>> SH;
    clamp = 0;
    if (r > 32767)       begin r = 32767;  clamp = 1; end
    else if (r < -32768) begin r = -32768; clamp = 1; end
    m_pend_v[i] = keep;
    m_pend_d[i] = int'(r);
    m_ovf[i] = ovf_set || (m_ovf[i] && !flag_clr);
    m_sat[i] = (keep && clamp) || (m_sat[i] && !flag_clr);
  endtask

  // Advance the model on each active edge.
  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  // Compare every output against the model away from the active edge; log pops.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("m_valid%0d", i), mv[i], m_valid[i]);
      check($sformatf("level%0d", i), lvl[i], mq[i].size());
      check($sformatf("ovf%0d", i), ovf_o[i], m_ovf[i]);
      check($sformatf("sat%0d", i), sat_o[i], m_sat[i]);
      if (m_valid[i]) check($sformatf("m_data%0d", i), $signed(md[i]), m_data[i]);
      if (mv[i] && rdy[i]) out_log[i].push_back(int'($signed(md[i])));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    valid_in = 0; sync = 0; flag_clr = 0;
    repeat (n) tick();
  endtask

  task automatic send(input longint v, input bit s);
    din = v[IW-1:0]; valid_in = 1; sync = s;
    tick();
    valid_in = 0; sync = 0;
  endtask

  task automatic reset_pulse();
    valid_in = 0; sync = 0; flag_clr = 0;
    rst = 0; tick(); rst = 1;
  endtask

  task automatic check_log(input int i, input string tag, input int exp[$]);
    check({tag, "_count"}, out_log[i].size(), exp.size());
    for (int k = 0; k < exp.size(); k++)
      check($sformatf("%s[%0d]", tag, k),
            (k < out_log[i].size()) ? out_log[i][k] : -999999, exp[k]);
  endtask

  int exp_q[$];

  initial begin
    rst = 0; valid_in = 0; din = '0; sync = 0; flag_clr = 0;
    rdy[0] = 1; rdy[1] = 1;
    repeat (2) tick();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_m_valid%0d", i), mv[i], 0);
      check($sformatf("rst_level%0d", i), lvl[i], 0);
      check($sformatf("rst_m_data%0d", i), md[i], 0);
      check($sformatf("rst_ovf%0d", i), ovf_o[i], 0);
      check($sformatf("rst_sat%0d", i), sat_o[i], 0);
    end
    rst = 1;

    // Rounding boundaries on the undecimated instance.
    out_log[0].delete();
    send(1535, 0); send(1536, 0); send(-1536, 0); send(-1537, 0);
    idle(6);
    exp_q = {1, 2, -1, -2};
    check_log(0, "round", exp_q);
    check("round_sat", sat_o[0], 0);

    // Saturation at both rails, then clearing the sticky flag.
    out_log[0].delete();
    send((longint'(1) << 25) - 1, 0); send(-(longint'(1) << 25), 0);
    idle(5);
    exp_q = {32767, -32768};
    check_log(0, "satur", exp_q);
    check("sat_set", sat_o[0], 1);
    flag_clr = 1; tick(); flag_clr = 0;
    check("sat_clr", sat_o[0], 0);

    // Decimation by 4 with latency check on the first kept sample.
    reset_pulse();
    out_log[1].delete();
    for (int k = 0; k < 16; k++) begin
      din = IW'(1024 * k); valid_in = 1;
      tick();
      if (k == 1) check("lat_edge1_valid", mv[1], 0);
      if (k == 2) check("lat_edge2_valid", mv[1], 1);
    end
    idle(6);
    exp_q = {0, 4, 8, 12};
    check_log(1, "decim", exp_q);

    // Sync realignment at sample 6.
    out_log[1].delete();
    for (int k = 0; k < 18; k++) send(1024 * k, k == 6);
    idle(6);
    exp_q = {0, 4, 6, 10, 14};
    check_log(1, "sync", exp_q);

    // Backpressure: overflow, then push-while-full with a pop.
    reset_pulse();
    out_log[0].delete();
    rdy[0] = 0;
    for (int k = 1; k <= 10; k++) send(1024 * k, 0);
    idle(4);
    check("bp_level", lvl[0], 8);
    check("bp_ovf", ovf_o[0], 1);
    check("bp_head", $signed(md[0]), 1);
    flag_clr = 1; tick(); flag_clr = 0;
    check("bp_ovf_clr", ovf_o[0], 0);
    send(1024 * 11, 0);
    rdy[0] = 1;
    tick();
    check("bp_full_pop_level", lvl[0], 8);
    check("bp_full_pop_ovf", ovf_o[0], 0);
    idle(14);
    exp_q = {1, 2, 3, 4, 5, 6, 7, 8, 11};
    check_log(0, "drain", exp_q);

    // Reset mid-operation with buffered data and a non-zero phase.
    send(0, 0);
    idle(3);
    rdy[0] = 0;
    for (int k = 1; k <= 5; k++) send(1024 * k, 0);
    idle(3);
    check("pre_rst_level", lvl[0], 5);
    reset_pulse();
    check("post_rst_level", lvl[0], 0);
    check("post_rst_valid", mv[0], 0);
    check("post_rst_ovf", ovf_o[0], 0);
    rdy[0] = 1;
    out_log[1].delete();
    send(1024 * 7, 0);
    idle(5);
    exp_q = {7};
    check_log(1, "rst_phase0", exp_q);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst      = ($urandom_range(0, 299) != 0);
      valid_in = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 0) din = IW'($urandom);
      else din = IW'(int'($urandom_range(0, 8191)) - 4096);
      sync     = ($urandom_range(0, 39) == 0);
      flag_clr = ($urandom_range(0, 49) == 0);
      rdy[0]   = ($urandom_range(0, 9) < 7);
      rdy[1]   = ($urandom_range(0, 9) < 4);
      tick();
    end
    rst = 1; rdy[0] = 1; rdy[1] = 1;
    idle(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
